fir_decim_requant: RTL and testbench
====================================

FIR_DECIM_REQUANT -- requirements
Module: fir_decim_requant

Interface
REQ-001 Parameter DECIM, default 4, decimation factor (legal 1..16).
REQ-002 Parameter SHIFT, default 2, arithmetic right-shift applied before saturation (legal 0..15).
REQ-003 Parameter DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 in_data  input  32  signed FIR accumulator sample.
REQ-007 in_en  input  1  in_data valid this cycle; no backpressure toward the filter.
REQ-008 out_data  output  16  signed requantized sample at the FIFO head.
REQ-009 out_valid  output  1  FIFO non-empty.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 ovf_sat  output  1  sticky flag: an accepted sample saturated.
REQ-012 drop  output  1  one-cycle pulse: a sample was discarded because the FIFO was full.
REQ-013 clr_flags  input  1  synchronous clear of ovf_sat.

Function
REQ-014 Phase counter 0..DECIM-1: advances on each in_en and wraps to 0 after DECIM-1; it holds when in_en=0.
REQ-015 A sample is accepted when in_en=1 and phase=0, so the first sample after reset is kept; with DECIM=1 every in_en sample is accepted.
REQ-016 Requant, computed in 33-bit signed: add 2^(SHIFT-1) (nothing when SHIFT=0), arithmetic shift right by SHIFT, then saturate to [-32768, 32767].
REQ-017 Stage 1 registers the requantized value and s1_valid on the accepting edge k; the FIFO write occurs at edge k+1; out_valid is high after edge k+1 when the FIFO was empty (latency 2).
REQ-018 FIFO push when s1_valid and (not full, or full with a simultaneous pop); the occupancy count stays correct under simultaneous push and pop at any fill level.
REQ-019 s1_valid with full and no pop: the sample is discarded, drop=1 for one cycle, and FIFO contents are unchanged.
REQ-020 There is no empty-FIFO bypass: a push into an empty FIFO is not visible on out_data in the same cycle.
REQ-021 Pop occurs on out_valid && out_ready; out_data holds stable while out_valid && !out_ready; output order is FIFO order.
REQ-022 ovf_sat sets when an accepted sample saturates and clears on clr_flags; if set and clear occur in the same cycle, set wins.
REQ-023 Read and write pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit or a count.

Reset
REQ-024 On reset: phase=0, s1_valid=0, FIFO empty, out_valid=0, out_data=0, ovf_sat=0, drop=0, all taking effect immediately without waiting for clk.
REQ-025 Reset mid-operation discards all pending samples; the first in_en after release is accepted as phase 0.

Structure
REQ-026 Package fir_pkg holds SAMPLE_W=16, ACC_W=32, OUT_W=16, OUT_MAX=32767, OUT_MIN=-32768, and the signed sample typedefs shared with the filter.
REQ-027 FIFO storage and pointer logic are implemented in sub-module fir_sample_fifo (parameters DEPTH and OUT_W); phase, requant and flag logic stay in the top module.

Verification
REQ-028 DECIM=1, SHIFT=2, in 100 then -6 -> out_data 25 then -1, in order, with out_valid two cycles after each input.
REQ-029 SHIFT=2, in 0x0010_0000 -> 32767 with ovf_sat=1; in 0x8000_0000 -> -32768; clr_flags -> ovf_sat=0; simultaneous saturate and clr -> ovf_sat=1.
REQ-030 DECIM=4, SHIFT=0, continuous in_en with in 1..8 -> outputs exactly 1, 5.
REQ-031 DEPTH=4, out_ready=0, 6 accepted samples 10..15 -> 4 stored, two drop pulses; then out_ready=1 -> outputs 10, 11, 12, 13.
REQ-032 FIFO full with out_ready=1 and a push in the same cycle -> no drop, stays full, order preserved.
REQ-033 Reset asserted mid-clock with 3 entries queued -> out_valid=0 immediately; after release, the first in_en sample is accepted and output 2 cycles later.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared widths, saturation limits and signed sample types for the FIR
// datapath and the requantizing decimator that sits behind it.
package fir_pkg;
  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 32;
  localparam int OUT_W    = 16;
  localparam int OUT_MAX  = 32767;
  localparam int OUT_MIN  = -32768;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]    acc_t;
  typedef logic signed [OUT_W-1:0]    out_t;
endpackage

// File: rtl/fir_sample_fifo.sv
// Output sample FIFO: DEPTH entries, occupancy counter separates full from
// empty, and an empty FIFO presents zero instead of stale storage.
module fir_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [OUT_W-1:0] data_i,
  input  logic             pop_i,
  output logic [OUT_W-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = empty_o ? '0 : mem[rd_q];

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wr_q + AW'(1);
    if (pop_i)  rd_d = rd_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem[wr_q] <= data_i;
  end
endmodule

// File: rtl/fir_decim_requant.sv
// Decimates the FIR accumulator stream, rounds/shifts/saturates to 16 bits,
// and queues results in an output FIFO with sticky overflow and drop pulse.
module fir_decim_requant
  import fir_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int SHIFT = 2,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [ACC_W-1:0] in_data,
  input  logic                    in_en,
  output logic signed [OUT_W-1:0] out_data,
  // Handshake: out_data is valid while out_valid=1; a sample leaves the FIFO
  // on every rising edge where out_valid && out_ready, otherwise it holds.
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    ovf_sat,
  output logic                    drop,
  input  logic                    clr_flags
);
  localparam logic [3:0]         PH_LAST = 4'(DECIM - 1);
  localparam logic signed [32:0] RND     = (SHIFT > 0) ? (33'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 33'sd0;
  localparam logic signed [32:0] SAT_HI  = 33'(OUT_MAX);
  localparam logic signed [32:0] SAT_LO  = 33'(OUT_MIN);

  logic [3:0]             phase_q, phase_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0]       s1_data_q, s1_data_d;
  logic                   ovf_q, ovf_d;
  logic                   drop_q, drop_d;
  logic                   accept;
  logic signed [32:0]     ext, shifted;
  logic [OUT_W-1:0]       req_data;
  logic                   req_sat;
  logic                   push, pop;
  logic                   fifo_full, fifo_empty;
  logic [OUT_W-1:0]       fifo_data;

  assign accept = in_en && (phase_q == 4'd0);

  // Rounding add and shift in 33 bits so the offset can never wrap the sum.
  always_comb begin
    ext      = {in_data[ACC_W-1], in_data};
    shifted  = (ext + RND) >>> SHIFT;
    req_data = shifted[OUT_W-1:0];
    req_sat  = 1'b0;
    if (shifted > SAT_HI) begin
      req_data = SAT_HI[OUT_W-1:0];
      req_sat  = 1'b1;
    end else if (shifted < SAT_LO) begin
      req_data = SAT_LO[OUT_W-1:0];
      req_sat  = 1'b1;
    end
  end

  assign pop  = out_valid && out_ready;
  assign push = s1_valid_q && (!fifo_full || pop);

  always_comb begin
    phase_d = phase_q;
    if (in_en) phase_d = (phase_q == PH_LAST) ? 4'd0 : phase_q + 4'd1;
    s1_valid_d = accept;
    s1_data_d  = accept ? req_data : s1_data_q;
    ovf_d      = (accept && req_sat) || (ovf_q && !clr_flags);
    drop_d     = s1_valid_q && fifo_full && !pop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  fir_sample_fifo #(
    .DEPTH (DEPTH),
    .OUT_W (OUT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (s1_data_q),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_data;
  assign ovf_sat   = ovf_q;
  assign drop      = drop_q;
endmodule

// File: tb/tb_fir_decim_requant.sv
// Directed bench: instance A (DECIM=1, SHIFT=2) covers requant, saturation,
// FIFO full/drop and reset; instance B (DECIM=4, SHIFT=0) covers decimation.
module tb_fir_decim_requant;
  logic clk = 1'b0;
  logic reset = 1'b1;

  logic signed [31:0] a_in_data = '0, b_in_data = '0;
  logic a_in_en = 1'b0, b_in_en = 1'b0;
  logic a_out_ready = 1'b0, b_out_ready = 1'b0;
  logic a_clr = 1'b0, b_clr = 1'b0;
  logic signed [15:0] a_out_data, b_out_data;
  logic a_out_valid, b_out_valid, a_ovf, b_ovf, a_drop, b_drop;

  int n_cmp = 0;
  int n_err = 0;
  int drops;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  fir_decim_requant #(.DECIM(1), .SHIFT(2), .DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_en(a_in_en),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .ovf_sat(a_ovf), .drop(a_drop), .clr_flags(a_clr)
  );

  fir_decim_requant #(.DECIM(4), .SHIFT(0), .DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_en(b_in_en),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .ovf_sat(b_ovf), .drop(b_drop), .clr_flags(b_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state, checked while reset is held
    #2;
    check("rst_valid", a_out_valid, 1'b0);
    check("rst_data", a_out_data, 0);
    check("rst_ovf", a_ovf, 1'b0);
    check("rst_drop", a_drop, 1'b0);
    step();
    reset = 1'b0;

    // Requant 100 -> 25, -6 -> -1 with two-cycle latency
    a_out_ready = 1'b1;
    a_in_en = 1'b1; a_in_data = 100;
    step();
    check("lat_not_yet", a_out_valid, 1'b0);
    a_in_data = -6;
    step();
    check("first_valid", a_out_valid, 1'b1);
    check("first_data", a_out_data, 25);
    a_in_en = 1'b0;
    step();
    check("second_data", a_out_data, -1);
    step();
    check("drained", a_out_valid, 1'b0);
    check("no_ovf", a_ovf, 1'b0);

    // Positive and negative saturation, sticky flag and clear
    a_in_en = 1'b1; a_in_data = 32'sh0010_0000;
    step();
    check("ovf_set", a_ovf, 1'b1);
    a_in_en = 1'b0;
    step();
    check("sat_hi", a_out_data, 32767);
    step();
    a_in_en = 1'b1; a_in_data = 32'sh8000_0000;
    step();
    a_in_en = 1'b0;
    step();
    check("sat_lo", a_out_data, -32768);
    step();
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    check("ovf_clr", a_ovf, 1'b0);
    a_in_en = 1'b1; a_in_data = 32'sh0010_0000; a_clr = 1'b1;
    step();
    a_in_en = 1'b0; a_clr = 1'b0;
    check("set_wins", a_ovf, 1'b1);
    step();
    step();
    check("empty_after_sat", a_out_valid, 1'b0);

    // Overfill: six samples, four stored, two drop pulses
    a_out_ready = 1'b0;
    drops = 0;
    for (int i = 0; i < 6; i++) begin
      a_in_en = 1'b1; a_in_data = (10 + i) * 4;
      step();
      drops += int'(a_drop);
    end
    a_in_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      drops += int'(a_drop);
    end
    check("drop_count", drops, 2);
    check("hold_data", a_out_data, 10);
    for (int v = 10; v < 14; v++) exp_q.push_back(16'(v));
    a_out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check("ovf_fill_order", a_out_data, $signed(exp_q.pop_front()));
      step();
    end
    check("ovf_fill_empty", a_out_valid, 1'b0);

    // Full FIFO with simultaneous pop and push: no drop, still full
    a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_in_en = 1'b1; a_in_data = (20 + i) * 4;
      step();
      check("fill_no_drop", a_drop, 1'b0);
    end
    a_in_en = 1'b0; a_out_ready = 1'b1;
    step();
    check("swap_no_drop", a_drop, 1'b0);
    check("swap_head", a_out_data, 21);
    a_out_ready = 1'b0;
    a_in_en = 1'b1; a_in_data = 25 * 4;
    step();
    a_in_en = 1'b0;
    step();
    check("still_full_drop", a_drop, 1'b1);
    step();
    check("drop_pulse_end", a_drop, 1'b0);
    for (int v = 21; v < 25; v++) exp_q.push_back(16'(v));
    a_out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check("swap_order", a_out_data, $signed(exp_q.pop_front()));
      step();
    end
    check("swap_empty", a_out_valid, 1'b0);

    // Decimate by 4: inputs 1..8 yield exactly 1 and 5
    b_out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      b_in_en = 1'b1; b_in_data = i;
      step();
    end
    b_in_en = 1'b0;
    step();
    step();
    check("dec_first", b_out_data, 1);
    b_out_ready = 1'b1;
    step();
    check("dec_second", b_out_data, 5);
    step();
    check("dec_only_two", b_out_valid, 1'b0);
    b_out_ready = 1'b0;
    b_in_en = 1'b1; b_in_data = 100;
    step();
    b_in_data = 101;
    step();
    b_in_en = 1'b0;
    step();
    check("dec_phase0", b_out_data, 100);

    // Asynchronous reset mid-cycle with three entries queued
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in_en = 1'b1; a_in_data = (30 + i) * 4;
      step();
    end
    a_in_en = 1'b0;
    step();
    step();
    check("queued_valid", a_out_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_valid", a_out_valid, 1'b0);
    check("async_data", a_out_data, 0);
    check("async_ovf", a_ovf, 1'b0);
    check("async_b_valid", b_out_valid, 1'b0);
    step();
    reset = 1'b0;
    a_in_en = 1'b1; a_in_data = 40 * 4;
    b_in_en = 1'b1; b_in_data = 7;
    step();
    a_in_en = 1'b0; b_in_en = 1'b0;
    check("post_rst_lat", a_out_valid, 1'b0);
    step();
    check("post_rst_valid", a_out_valid, 1'b1);
    check("post_rst_data", a_out_data, 40);
    check("post_rst_b_data", b_out_data, 7);
    check("post_rst_b_valid", b_out_valid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
